// File: rtl/rf_ctx_if.sv
// rf_ctx_if: decode/datapath-side bus of the rf_ctx register file
interface rf_ctx_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          we;
  logic [AW-1:0] ptr_w;
  logic [DW-1:0] di;
  logic [AW-1:0] ptr_a;
  logic [DW-1:0] ptr_b;
  logic          const_flag;
  logic          r_overflow;
  logic          snap_req;
  logic          rest_req;
  logic [DW-1:0] do_a;
  logic [DW-1:0] do_b;
  logic [DW-1:0] store_value;
  logic          busy;
  logic          done;
  modport master (
    output we, ptr_w, di, ptr_a, ptr_b, const_flag, r_overflow, snap_req, rest_req,
    input  do_a, do_b, store_value, busy, done
  );
  modport slave (
    input  we, ptr_w, di, ptr_a, ptr_b, const_flag, r_overflow, snap_req, rest_req,
    output do_a, do_b, store_value, busy, done
  );
endinterface

// File: rtl/rf_ctx.sv
// rf_ctx: register file with zero reg, overflow flag reg and sequenced shadow snapshot/restore; RF_CTX_BYPASS_EN adds write-to-read bypass
module rf_ctx #(
  parameter int DW       = 8,
  parameter int NREG     = 9,
  parameter int AW       = 5,
  parameter int FLAG_IDX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_ctx_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, SNAP, REST} st_t;
  st_t           st_q, st_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [DW-1:0] live_q [NREG];
  logic [DW-1:0] live_d [NREG];
  logic [DW-1:0] shadow_q [NREG];
  logic [DW-1:0] shadow_d [NREG];
  logic          wr_ok;
  logic          last;
  logic [AW-1:0] pb;
  logic [DW-1:0] ra, rb, rs;
  assign pb    = bus.ptr_b[AW-1:0];
  assign wr_ok = bus.we && st_q != REST && bus.ptr_w != '0 && int'(bus.ptr_w) < NREG;
  assign last  = idx_q == AW'(NREG - 1);
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (st_q == IDLE) begin
      st_d  = bus.snap_req ? SNAP : bus.rest_req ? REST : IDLE;
      idx_d = AW'(1);
    end else if (last) begin
      st_d   = IDLE;
      done_d = 1'b1;
    end else begin
      idx_d = idx_q + AW'(1);
    end
  end
  // later assignments win: flag sampling < normal write < restore copy
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      live_d[i]   = live_q[i];
      shadow_d[i] = shadow_q[i];
      if (i == FLAG_IDX) live_d[i] = {{(DW-1){1'b0}}, bus.r_overflow};
      if (wr_ok && int'(bus.ptr_w) == i) live_d[i] = bus.di;
      if (st_q == REST && int'(idx_q) == i) live_d[i] = shadow_q[i];
      if (st_q == SNAP && int'(idx_q) == i) shadow_d[i] = live_q[i];
    end
  end
  always_comb begin
    ra = '0;
    rb = '0;
    rs = '0;
    for (int i = 1; i < NREG; i++) begin
      if (int'(bus.ptr_a) == i) ra = live_q[i];
      if (int'(pb) == i) rb = live_q[i];
      if (int'(bus.ptr_w) == i) rs = live_q[i];
    end
`ifdef RF_CTX_BYPASS_EN
    ra = (wr_ok && bus.ptr_a == bus.ptr_w) ? bus.di : ra;
    rb = (wr_ok && pb == bus.ptr_w) ? bus.di : rb;
    rs = wr_ok ? bus.di : rs;
`endif
  end
  assign bus.do_a        = ra;
  assign bus.do_b        = bus.const_flag ? bus.ptr_b : rb;
  assign bus.store_value = rs;
  assign bus.busy        = st_q != IDLE;
  assign bus.done        = done_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      for (int i = 0; i < NREG; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end
endmodule

// File: tb/tb_rf_ctx.sv
// tb_rf_ctx: vector table, hand-written snapshot/restore/abort sequences and a randomized run against a behavioural model
module tb_rf_ctx;
  localparam int DW = 8, NREG = 9, AW = 5;
`ifdef RF_CTX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  rf_ctx_if #(.DW(DW), .AW(AW)) bus ();
  rf_ctx #(.DW(DW), .NREG(NREG), .AW(AW), .FLAG_IDX(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_live [NREG];
  logic [7:0] m_shadow [NREG];
  int m_kind = 0, m_pos = 0;
  bit m_done = 1'b0;
  typedef struct {
    logic we; logic [4:0] pw; logic [7:0] di; logic [4:0] pa; logic [7:0] pb;
    logic cf; logic ov; logic [7:0] ea; logic [7:0] eb;
  } vec_t;
  vec_t v [9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a write lands only if enabled, nonzero, in range and no restore is running
  function automatic bit acc_w();
    return bus.we && bus.ptr_w != 0 && int'(bus.ptr_w) < NREG && m_kind != 2;
  endfunction

  function automatic logic [7:0] m_rd(logic [4:0] p);
    logic [7:0] r;
    r = 8'h00;
    if (p != 0 && int'(p) < NREG) r = m_live[int'(p)];
    if (BYP && acc_w() && p == bus.ptr_w) r = bus.di;
    return r;
  endfunction

  task automatic m_edge();
    logic [7:0] nl [NREG];
    logic [7:0] ns [NREG];
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_live[i] = 8'h00;
        m_shadow[i] = 8'h00;
      end
      m_kind = 0;
      m_done = 1'b0;
      return;
    end
    nl = m_live;
    ns = m_shadow;
    nl[8] = {7'b0, bus.r_overflow};
    if (acc_w()) nl[int'(bus.ptr_w)] = bus.di;
    if (m_kind == 1) ns[m_pos] = m_live[m_pos];
    else if (m_kind == 2) nl[m_pos] = m_shadow[m_pos];
    m_done = m_kind != 0 && m_pos == NREG - 1;
    if (m_kind == 0) begin
      if (bus.snap_req) begin m_kind = 1; m_pos = 1; end
      else if (bus.rest_req) begin m_kind = 2; m_pos = 1; end
    end else if (m_pos == NREG - 1) m_kind = 0;
    else m_pos++;
    m_live = nl;
    m_shadow = ns;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.we = 0; bus.ptr_w = 0; bus.di = 0; bus.ptr_a = 0; bus.ptr_b = 0;
    bus.const_flag = 0; bus.r_overflow = 0; bus.snap_req = 0; bus.rest_req = 0;
    rst_n = 1;
  endtask

  task automatic wr(logic [4:0] p, logic [7:0] d);
    bus.we = 1; bus.ptr_w = p; bus.di = d;
    tick();
    bus.we = 0;
  endtask

  task automatic cmp_all(string t);
    chk({t, "_do_a"}, bus.do_a, m_rd(bus.ptr_a));
    chk({t, "_do_b"}, bus.do_b, bus.const_flag ? bus.ptr_b : m_rd(bus.ptr_b[4:0]));
    chk({t, "_store"}, bus.store_value, m_rd(bus.ptr_w));
    chk({t, "_busy"}, bus.busy, m_kind != 0);
    chk({t, "_done"}, bus.done, m_done);
  endtask

  task automatic run_seq(string t, int exp_len, bit poke_we);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      if (poke_we && n == 3) begin bus.we = 1; bus.ptr_w = 2; bus.di = 8'h99; end
      else bus.we = 0;
      tick();
    end
    bus.we = 0;
    chk({t, "_busy_len"}, n, exp_len);
    chk({t, "_done"}, bus.done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    // reset clears a written register
    wr(5'd3, 8'hAA);
    bus.ptr_a = 3;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst_do_a", bus.do_a, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    v[0] = '{1'b1, 5'd2, 8'h5C, 5'd0,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    v[1] = '{1'b1, 5'd0, 8'h77, 5'd2,  8'h02, 1'b0, 1'b0, 8'h5C, 8'h5C};
    v[2] = '{1'b0, 5'd0, 8'h00, 5'd0,  8'h0C, 1'b0, 1'b0, 8'h00, 8'h00};
    v[3] = '{1'b0, 5'd0, 8'h00, 5'd12, 8'hF3, 1'b1, 1'b0, 8'h00, 8'hF3};
    v[4] = '{1'b1, 5'd4, 8'h11, 5'd4,  8'h02, 1'b0, 1'b1, BYP ? 8'h11 : 8'h00, 8'h5C};
    v[5] = '{1'b0, 5'd0, 8'h00, 5'd4,  8'h08, 1'b0, 1'b0, 8'h11, 8'h01};
    v[6] = '{1'b1, 5'd8, 8'h40, 5'd8,  8'h08, 1'b0, 1'b1, BYP ? 8'h40 : 8'h00, BYP ? 8'h40 : 8'h00};
    v[7] = '{1'b0, 5'd0, 8'h00, 5'd8,  8'h28, 1'b0, 1'b0, 8'h40, 8'h40};
    v[8] = '{1'b0, 5'd0, 8'h00, 5'd8,  8'h04, 1'b0, 1'b0, 8'h00, 8'h11};
    for (int i = 0; i < 9; i++) begin
      bus.we = v[i].we; bus.ptr_w = v[i].pw; bus.di = v[i].di; bus.ptr_a = v[i].pa;
      bus.ptr_b = v[i].pb; bus.const_flag = v[i].cf; bus.r_overflow = v[i].ov;
      #1;
      chk($sformatf("vec%0d_do_a", i), bus.do_a, v[i].ea);
      chk($sformatf("vec%0d_do_b", i), bus.do_b, v[i].eb);
      tick();
    end
    idle_in();
    // snapshot of r1..r7 = 1..7, clobber, then restore with an ignored write mid-restore
    for (int i = 1; i < 8; i++) wr(5'(i), 8'(i));
    bus.snap_req = 1;
    tick();
    bus.snap_req = 0;
    run_seq("snap", 8, 1'b0);
    tick();
    chk("snap_done_once", bus.done, 0);
    for (int i = 1; i < 8; i++) wr(5'(i), 8'hFF);
    bus.rest_req = 1;
    tick();
    bus.rest_req = 0;
    run_seq("rest", 8, 1'b1);
    for (int i = 1; i < 8; i++) begin
      bus.ptr_a = 5'(i);
      #1;
      chk($sformatf("rest_r%0d", i), bus.do_a, i);
    end
    tick();
    // both requests together run a snapshot; rest_req while busy is dropped
    wr(5'd1, 8'h33);
    bus.snap_req = 1; bus.rest_req = 1;
    tick();
    bus.snap_req = 0; bus.rest_req = 0;
    chk("arb_busy", bus.busy, 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      bus.rest_req = n >= 2 && n <= 7;
      tick();
    end
    bus.rest_req = 0;
    chk("arb_busy_len", n, 8);
    chk("arb_done", bus.done, 1);
    tick();
    chk("arb_no_queue", bus.busy, 0);
    bus.ptr_a = 1;
    #1;
    chk("arb_r1", bus.do_a, 8'h33);
    // reset in the 4th busy cycle aborts and clears the shadow bank
    bus.snap_req = 1;
    tick();
    bus.snap_req = 0;
    tick(); tick(); tick();
    chk("abort_busy4", bus.busy, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    tick();
    chk("abort_no_done", bus.done, 0);
    wr(5'd1, 8'h55);
    bus.rest_req = 1;
    tick();
    bus.rest_req = 0;
    run_seq("abort_rest", 8, 1'b0);
    bus.ptr_a = 1;
    #1;
    chk("abort_shadow_r1", bus.do_a, 8'h00);
    tick();
    for (int c = 0; c < 600; c++) begin
      bus.we = 1'($urandom_range(0, 1));
      bus.ptr_w = 5'($urandom_range(0, 15));
      bus.di = 8'($urandom);
      bus.ptr_a = 5'($urandom_range(0, 15));
      bus.ptr_b = 8'($urandom);
      bus.const_flag = $urandom_range(0, 3) == 0;
      bus.r_overflow = 1'($urandom_range(0, 1));
      bus.snap_req = $urandom_range(0, 15) == 0;
      bus.rest_req = $urandom_range(0, 15) == 0;
      rst_n = $urandom_range(0, 99) != 0;
      #1;
      cmp_all("rnd");
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_ctx.md
# rf_ctx

Parametrised successor to the core's 8-bit register file. It provides a synchronous-write, combinational-read register bank with:
- a hardwired zero register and a constant pass-through on port B;
- a hardware overflow-flag register;
- a store-data read port;
- a single shadow bank with sequenced snapshot/restore for interrupt/context-switch use.

It sits between decode (pointers, constant flag) and the ALU/data-memory datapath.

## Interface
- DW, 8, data width of every register and of `ptr_b`.
- NREG, 9, number of registers; index 0 reads as zero.
- AW, 5, pointer width; NREG ≤ 2^AW.
- FLAG_IDX, 8, index of the overflow-flag register; 1 ≤ FLAG_IDX < NREG.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- we  in  1  write enable.
- ptr_w  in  AW  write pointer; also selects `store_value`.
- di  in  DW  write data.
- ptr_a  in  AW  read pointer A.
- ptr_b  in  DW  read pointer B, or constant when `const_flag`=1; low AW bits are the pointer.
- const_flag  in  1  port B returns `ptr_b` verbatim.
- r_overflow  in  1  ALU overflow, sampled every cycle into the flag register.
- snap_req  in  1  request snapshot (live → shadow).
- rest_req  in  1  request restore (shadow → live).
- do_a  out  DW  read data A.
- do_b  out  DW  read data B or constant.
- store_value  out  DW  contents of register `ptr_w`.
- busy  out  1  snapshot/restore sequence in progress.
- done  out  1  one-cycle pulse at sequence end.

## Operation
- Reads are combinational:
  - Index 0 returns 0.
  - An index ≥ NREG returns 0.
  - `const_flag`=1 forces `do_b` = `ptr_b` regardless of the pointer.
- Writes are synchronous. A write with `we`=1 to index 0 or to an index ≥ NREG is ignored.
- Flag register: each cycle it loads {(DW-1)'b0, `r_overflow`}. A same-cycle `we` to FLAG_IDX takes priority and loads `di`.
- The FSM has three states: IDLE, SNAP and REST.
- IDLE transitions:
  - `snap_req` → SNAP.
  - `rest_req` → REST.
  - Both requests together → SNAP (snapshot wins).
  - Requests outside IDLE are ignored; they are not queued.
- SNAP copies live[i] into shadow[i] for i = 1..NREG-1, one register per cycle in ascending order.
  - Normal writes remain accepted during SNAP.
  - shadow[i] captures the live[i] value stored at the start of its copy cycle.
- REST copies shadow[i] into live[i] for i = 1..NREG-1, one register per cycle in ascending order.
  - `we` is ignored for the whole REST sequence.
  - The flag-register `r_overflow` update is suppressed in the REST cycle that writes FLAG_IDX.
- `busy`=1 in every SNAP/REST cycle. After the last index the FSM returns to IDLE and `done`=1 for exactly that IDLE cycle.

## Timing
- Reset (`rst_n`=0 at an edge) clears all live and shadow registers to 0 and sets the FSM to IDLE.
  - Outputs after reset: `busy`=0, `done`=0. `do_a`, `do_b` and `store_value` read 0 unless `const_flag`=1.
- Reset asserted mid-sequence aborts it immediately. `done` is not pulsed.
- Write latency is 1 cycle: the value written at edge k is readable after edge k.
- Sequence length:
  - A request sampled at edge k gives `busy`=1 in cycles k+1 .. k+NREG-1.
  - `done`=1 in cycle k+NREG.
  - A new request is accepted at the edge that ends the `done` cycle.
- Default NREG=9 gives 8 busy cycles.

## Configuration
- Macro: `RF_CTX_BYPASS_EN`.
- Defined:
  - If a read pointer equals `ptr_w` with `we`=1 (write actually accepted, nonzero, in range), the read port returns `di` in the same cycle.
  - This applies to `do_a`, `do_b` (when `const_flag`=0) and `store_value`.
  - Bypass is suppressed during REST.
- Not defined: reads return the stored, pre-write value until the next cycle.

## Test plan
- Reset: write 0xAA to r3, pulse `rst_n`=0 for 1 cycle, read `ptr_a`=3 → `do_a`=0x00, `busy`=0, `done`=0.
- Basic write and zero register:
  - Write 0x5C to r2, then `ptr_a`=2 → 0x5C.
  - Write 0x77 to r0, then `ptr_a`=0 → 0x00.
  - `ptr_a`=12 (≥ NREG) → 0x00.
- Constant and bypass:
  - `const_flag`=1, `ptr_b`=0xF3 → `do_b`=0xF3.
  - Same-cycle write 0x11 to r4 with `ptr_a`=4 → 0x11 with `RF_CTX_BYPASS_EN`, old value (0x00) without it.
- Flag register:
  - `r_overflow`=1 → r8 reads 0x01 the next cycle.
  - Simultaneous `we` to r8 with `di`=0x40 and `r_overflow`=1 → r8 = 0x40.
- Snapshot then restore:
  - Load r1..r7 = 0x01..0x07, then `snap_req` → `busy` for 8 cycles, then `done` for 1 cycle.
  - Overwrite r1..r7 with 0xFF, then `rest_req` → after `done`, r1..r7 = 0x01..0x07.
  - A `we` issued during REST has no effect.
- Arbitration and abort:
  - `snap_req` and `rest_req` together → SNAP runs.
  - `rest_req` during busy is ignored.
  - `rst_n`=0 in the 4th busy cycle → `busy`=0 next cycle, no `done` pulse, shadow cleared.
